// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor y = a - b with borrow/overflow flag
module serial_subtractor #(
  parameter int IN_WIDTH = 8,
  parameter bit SIGNED   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [IN_WIDTH:0]   y,
  output logic                v
);

  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_next;

  // Operands carry one extension bit so bit IN_WIDTH falls out of the shift naturally.
  logic [IN_WIDTH:0]   a_sr, b_sr;
  // Holds the first IN_WIDTH difference bits; the final bit goes straight to y.
  logic [IN_WIDTH-1:0] acc;
  logic                a_msb, b_msb;
  logic                br;
  logic [CW-1:0]       cnt;
  logic                accept, last;
  logic                d, br_next;

  // Full-subtractor cell on the current LSBs.
  assign d       = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == '0) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, one bit per cycle, result commit on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      br    <= 1'b0;
      cnt   <= '0;
      y     <= '0;
      v     <= 1'b0;
    end else if (accept) begin
      a_sr  <= {(SIGNED ? a[IN_WIDTH-1] : 1'b0), a};
      b_sr  <= {(SIGNED ? b[IN_WIDTH-1] : 1'b0), b};
      a_msb <= a[IN_WIDTH-1];
      b_msb <= b[IN_WIDTH-1];
      acc   <= '0;
      br    <= 1'b0;
      cnt   <= CW'(IN_WIDTH);
    end else if (busy) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      acc  <= {d, acc[IN_WIDTH-1:1]};
      br   <= br_next;
      if (last) begin
        y <= {d, acc};
        // acc[IN_WIDTH-1] is the committed y[IN_WIDTH-1].
        v <= SIGNED ? ((a_msb ^ b_msb) & (acc[IN_WIDTH-1] ^ a_msb)) : br_next;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
